// File: rtl/de_pipe.sv
// de_pipe: decode-to-execute pipeline register.
// Captures decode-stage control, ALU control, register index, operands and
// immediate every rising edge; a synchronous flush loads an all-zero bubble,
// and an asynchronous active-high reset clears every field.
module de_pipe (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush_E,
   input  logic        pcload_D,
   input  logic        regw_D,
   input  logic        memw_D,
   input  logic        regmem_D,
   input  logic        branch_D,
   input  logic        ALUope_D,
   input  logic        flag_D,
   input  logic [3:0]  ALUctrl_D,
   input  logic [3:0]  regScr_D,
   input  logic [31:0] regA_D,
   input  logic [31:0] regB_D,
   input  logic [18:0] inm_D,
   output logic        pcload_E,
   output logic        regw_E,
   output logic        memw_E,
   output logic        regmem_E,
   output logic        branch_E,
   output logic        ALUope_E,
   output logic        flag_E,
   output logic [3:0]  ALUctrl_E,
   output logic [3:0]  regScr_E,
   output logic [31:0] regA_E,
   output logic [31:0] regB_E,
   output logic [18:0] inm_E
);

   localparam int unsigned CTRL_W = 7;
   localparam int unsigned ALU_W  = 4;
   localparam int unsigned REG_W  = 4;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned INM_W  = 19;

   logic [CTRL_W-1:0] w_ctrl_d;
   logic [CTRL_W-1:0] r_ctrl;
   logic [ALU_W-1:0]  r_aluctrl;
   logic [REG_W-1:0]  r_regscr;
   logic [DATA_W-1:0] r_rega;
   logic [DATA_W-1:0] r_regb;
   logic [INM_W-1:0]  r_inm;

   // Gather the single-bit decode controls into one field.
   assign w_ctrl_d = {pcload_D, regw_D, memw_D, regmem_D, branch_D, ALUope_D, flag_D};

   // Pipeline register: reset > flush (bubble) > normal load.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ctrl    <= '0;
         r_aluctrl <= '0;
         r_regscr  <= '0;
         r_rega    <= '0;
         r_regb    <= '0;
         r_inm     <= '0;
      end else if (flush_E) begin
         r_ctrl    <= '0;
         r_aluctrl <= '0;
         r_regscr  <= '0;
         r_rega    <= '0;
         r_regb    <= '0;
         r_inm     <= '0;
      end else begin
         r_ctrl    <= w_ctrl_d;
         r_aluctrl <= ALUctrl_D;
         r_regscr  <= regScr_D;
         r_rega    <= regA_D;
         r_regb    <= regB_D;
         r_inm     <= inm_D;
      end
   end

   // Outputs come straight from the flops.
   assign {pcload_E, regw_E, memw_E, regmem_E, branch_E, ALUope_E, flag_E} = r_ctrl;
   assign ALUctrl_E = r_aluctrl;
   assign regScr_E  = r_regscr;
   assign regA_E    = r_rega;
   assign regB_E    = r_regb;
   assign inm_E     = r_inm;

endmodule

// File: tb/tb_de_pipe.sv
// Self-checking bench for de_pipe: directed scenarios plus randomized
// load/flush/reset traffic against a one-slot reference model.
module tb_de_pipe;

   localparam int unsigned BUS_W = 98;

   logic        clk;
   logic        rst;
   logic        flush_E;
   logic        pcload_D, regw_D, memw_D, regmem_D, branch_D, ALUope_D, flag_D;
   logic [3:0]  ALUctrl_D, regScr_D;
   logic [31:0] regA_D, regB_D;
   logic [18:0] inm_D;
   logic        pcload_E, regw_E, memw_E, regmem_E, branch_E, ALUope_E, flag_E;
   logic [3:0]  ALUctrl_E, regScr_E;
   logic [31:0] regA_E, regB_E;
   logic [18:0] inm_E;

   int checks;
   int failures;

   de_pipe dut (
      .clk(clk), .rst(rst), .flush_E(flush_E),
      .pcload_D(pcload_D), .regw_D(regw_D), .memw_D(memw_D), .regmem_D(regmem_D),
      .branch_D(branch_D), .ALUope_D(ALUope_D), .flag_D(flag_D),
      .ALUctrl_D(ALUctrl_D), .regScr_D(regScr_D), .regA_D(regA_D), .regB_D(regB_D),
      .inm_D(inm_D),
      .pcload_E(pcload_E), .regw_E(regw_E), .memw_E(memw_E), .regmem_E(regmem_E),
      .branch_E(branch_E), .ALUope_E(ALUope_E), .flag_E(flag_E),
      .ALUctrl_E(ALUctrl_E), .regScr_E(regScr_E), .regA_E(regA_E), .regB_E(regB_E),
      .inm_E(inm_E)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bus order: {pcload,regw,memw,regmem,branch,ALUope,flag,ALUctrl,regScr,regA,regB,inm}
   task automatic set_d(input logic [BUS_W-1:0] v);
      {pcload_D, regw_D, memw_D, regmem_D, branch_D, ALUope_D, flag_D,
       ALUctrl_D, regScr_D, regA_D, regB_D, inm_D} = v;
   endtask

   function automatic logic [BUS_W-1:0] get_e();
      return {pcload_E, regw_E, memw_E, regmem_E, branch_E, ALUope_E, flag_E,
              ALUctrl_E, regScr_E, regA_E, regB_E, inm_E};
   endfunction

   function automatic logic [BUS_W-1:0] rand_bus();
      logic [127:0] r;
      r = {$urandom, $urandom, $urandom, $urandom};
      return r[BUS_W-1:0];
   endfunction

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [BUS_W-1:0] got;
      rst = 1'b1;
      flush_E = 1'b0;
      set_d({BUS_W{1'b1}});
      #1;
      got = get_e();
      checks++;
      if (got !== '0) begin
         failures++;
         $display("FAIL reset_immediate got=%h want=0", got);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         got = get_e();
         checks++;
         if (got !== '0) begin
            failures++;
            $display("FAIL reset_hold[%0d] got=%h want=0", i, got);
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [BUS_W-1:0] a, b, got;
      a = {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0101, 4'b0011,
           32'h0000FFFF, 32'h00000801, 19'h00000};
      b = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0010, 4'b0100,
           32'h0000FFFF, 32'h00000000, 19'h00401};
      set_d(a);
      tick();
      got = get_e();
      checks++;
      if (got !== a) begin
         failures++;
         $display("FAIL load_a got=%h want=%h", got, a);
      end
      set_d(b);
      #2;
      got = get_e();
      checks++;
      if (got !== a) begin
         failures++;
         $display("FAIL hold_a_before_edge got=%h want=%h", got, a);
      end
      tick();
      got = get_e();
      checks++;
      if (got !== b) begin
         failures++;
         $display("FAIL load_b got=%h want=%h", got, b);
      end
   endtask

   task automatic test_flush();
      logic [BUS_W-1:0] got, nv;
      flush_E = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         got = get_e();
         checks++;
         if (got !== '0) begin
            failures++;
            $display("FAIL flush[%0d] got=%h want=0", i, got);
         end
         set_d(rand_bus());
      end
      flush_E = 1'b0;
      nv = rand_bus();
      set_d(nv);
      tick();
      got = get_e();
      checks++;
      if (got !== nv) begin
         failures++;
         $display("FAIL flush_release got=%h want=%h", got, nv);
      end
   endtask

   task automatic test_async_reset();
      logic [BUS_W-1:0] v, got;
      v = rand_bus() | {{(BUS_W-1){1'b0}}, 1'b1};
      set_d(v);
      tick();
      #1;
      rst = 1'b1;
      #1;
      got = get_e();
      checks++;
      if (got !== '0) begin
         failures++;
         $display("FAIL async_reset got=%h want=0", got);
      end
      #1;
      rst = 1'b0;
      #1;
      got = get_e();
      checks++;
      if (got !== '0) begin
         failures++;
         $display("FAIL post_reset_hold got=%h want=0", got);
      end
      v = rand_bus();
      set_d(v);
      tick();
      got = get_e();
      checks++;
      if (got !== v) begin
         failures++;
         $display("FAIL post_reset_load got=%h want=%h", got, v);
      end
   endtask

   // Reference: the slot holds the last edge's inputs, or zero for flush/reset.
   task automatic test_random();
      logic [BUS_W-1:0] v, exp, got;
      for (int i = 0; i < 300; i++) begin
         v = rand_bus();
         set_d(v);
         flush_E = ($urandom_range(0, 3) == 0);
         exp = flush_E ? '0 : v;
         tick();
         got = get_e();
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL random[%0d] flush=%0b got=%h want=%h", i, flush_E, got, exp);
         end
         set_d(rand_bus());
         if ($urandom_range(0, 15) == 0) begin
            #1;
            rst = 1'b1;
            #1;
            got = get_e();
            checks++;
            if (got !== '0) begin
               failures++;
               $display("FAIL random_reset[%0d] got=%h want=0", i, got);
            end
            rst = 1'b0;
         end
      end
      flush_E = 1'b0;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_back_to_back();
      test_flush();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
